// File: rtl/ladybird_config.sv
// rtl/ladybird_config.sv - shared boot loader constants and state types.
package ladybird_config;

  localparam int unsigned XLEN = 32;

  localparam logic [7:0]  BOOT_ACK = 8'h06;
  localparam logic [7:0]  BOOT_NAK = 8'h15;
  localparam logic [31:0] BOOT_UART_ADDR = 32'hffff_ffff;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_MEM,
    S_ACK,
    S_NAK,
    S_DONE,
    S_ERR
  } boot_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT
  } rd_state_e;

endpackage

// File: rtl/ladybird_boot_byte_reader.sv
// rtl/ladybird_boot_byte_reader.sv - one UART byte read per request, handed to the boot FSM.
module ladybird_boot_byte_reader (
  input  logic       clk,
  input  logic       anrst,
  input  logic       rd_en_i,
  input  logic       gnt_i,
  input  logic       data_gnt_i,
  input  logic [7:0] rdata_i,
  output logic       req_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o
);
  import ladybird_config::*;

  rd_state_e  state_q, state_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q <= RD_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // The cycle a byte is presented the FSM may be changing state, so no new read starts then.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      RD_IDLE: if (rd_en_i && !valid_q) state_d = RD_REQ;
      RD_REQ:  if (gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (data_gnt_i) begin
          state_d = RD_IDLE;
          valid_d = 1'b1;
          data_d  = rdata_i;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    req_o        = (state_q == RD_REQ);
    byte_valid_o = valid_q;
    byte_data_o  = data_q;
  end

endmodule

// File: rtl/ladybird_boot_loader.sv
// rtl/ladybird_boot_loader.sv - loads a length-prefixed image from UART into IRAM, then releases the core.
module ladybird_boot_loader #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 8,
  parameter logic [XLEN-1:0]   UART_ADDR = '1
) (
  input  logic                           clk,
  input  logic                           anrst,
  output logic                           uart_req,
  output logic [XLEN-1:0]                uart_addr,
  output logic [XLEN/8-1:0]              uart_wstrb,
  output logic [XLEN-1:0]                uart_wdata,
  output logic                           uart_wdata_oe,
  input  logic                           uart_gnt,
  input  logic                           uart_data_gnt,
  input  logic [XLEN-1:0]                uart_rdata,
  output logic                           mem_req,
  output logic [XLEN-1:0]                mem_addr,
  output logic [XLEN/8-1:0]              mem_wstrb,
  output logic [XLEN-1:0]                mem_wdata,
  output logic                           mem_wdata_oe,
  input  logic                           mem_gnt,
  input  logic                           reload,
  output logic                           core_nrst,
  output logic                           error,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_cnt
);
  import ladybird_config::*;

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  boot_state_e     state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [XLEN-1:0] len_q, len_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            rd_en;
  logic            rd_req;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic [XLEN-1:0] assembled;
  logic [XLEN-1:0] cnt_next_wide;
  logic            wr_uart;
  logic            unused_rdata_hi;

  assign unused_rdata_hi = ^uart_rdata[XLEN-1:8];

  ladybird_boot_byte_reader u_reader (
    .clk          (clk),
    .anrst        (anrst),
    .rd_en_i      (rd_en),
    .gnt_i        (uart_gnt),
    .data_gnt_i   (uart_data_gnt),
    .rdata_i      (uart_rdata[7:0]),
    .req_o        (rd_req),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data)
  );

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q <= S_LEN;
      idx_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Little-endian insertion of the incoming byte into whichever register is being filled.
  always_comb begin
    assembled = (state_q == S_LEN) ? len_q : word_q;
    assembled[{idx_q, 3'b000} +: 8] = byte_data;
  end

  assign cnt_next_wide = XLEN'(cnt_q) + XLEN'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LEN: begin
        if (byte_valid) begin
          len_d = assembled;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (assembled > XLEN'(MAX_WORDS)) state_d = S_NAK;
            else if (assembled == '0)        state_d = S_ACK;
            else                             state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_valid) begin
          word_d = assembled;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_gnt) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_next_wide == len_q) ? S_ACK : S_DATA;
        end
      end
      S_ACK: if (uart_gnt) state_d = S_DONE;
      S_NAK: if (uart_gnt) state_d = S_ERR;
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_LEN;
          idx_d   = '0;
          len_d   = '0;
          word_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_LEN;
    endcase
  end

  // UART ownership: the byte reader during S_LEN/S_DATA, the FSM for the ACK/NAK write.
  always_comb begin
    rd_en         = (state_q == S_LEN) || (state_q == S_DATA);
    wr_uart       = (state_q == S_ACK) || (state_q == S_NAK);
    uart_req      = rd_req || wr_uart;
    uart_addr     = uart_req ? UART_ADDR : '0;
    uart_wstrb    = wr_uart ? '1 : '0;
    uart_wdata_oe = wr_uart;
    uart_wdata    = '0;
    if (wr_uart) uart_wdata = XLEN'((state_q == S_ACK) ? BOOT_ACK : BOOT_NAK);

    mem_req       = (state_q == S_MEM);
    mem_addr      = mem_req ? (BASE_ADDR + (XLEN'(cnt_q) << 2)) : '0;
    mem_wstrb     = mem_req ? '1 : '0;
    mem_wdata     = mem_req ? word_q : '0;
    mem_wdata_oe  = mem_req;

    core_nrst     = (state_q == S_DONE);
    error         = (state_q == S_ERR);
    word_cnt      = cnt_q;
  end

endmodule

// File: tb/tb_ladybird_boot_loader.sv
// tb/tb_ladybird_boot_loader.sv - randomized self-checking bench for the UART boot loader.
module tb_ladybird_boot_loader;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        anrst = 1'b0;
  logic        reload = 1'b0;
  logic        uart_req, uart_wdata_oe, uart_gnt, uart_data_gnt;
  logic [31:0] uart_addr, uart_wdata, uart_rdata;
  logic [3:0]  uart_wstrb, mem_wstrb;
  logic        mem_req, mem_wdata_oe, mem_gnt;
  logic [31:0] mem_addr, mem_wdata;
  logic        core_nrst, error;
  logic [3:0]  word_cnt;

  logic dg_model = 1'b0;
  logic dg_force = 1'b0;
  assign uart_data_gnt = dg_model | dg_force;

  always #5 clk = ~clk;

  ladybird_boot_loader #(
    .XLEN(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAXW), .UART_ADDR(32'hffff_ffff)
  ) dut (
    .clk(clk), .anrst(anrst),
    .uart_req(uart_req), .uart_addr(uart_addr), .uart_wstrb(uart_wstrb),
    .uart_wdata(uart_wdata), .uart_wdata_oe(uart_wdata_oe),
    .uart_gnt(uart_gnt), .uart_data_gnt(uart_data_gnt), .uart_rdata(uart_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_gnt(mem_gnt),
    .reload(reload), .core_nrst(core_nrst), .error(error), .word_cnt(word_cnt)
  );

  int checks = 0, passed = 0, failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host image and reference expectations (written by main only)
  logic [7:0]  host_bytes [0:63];
  int          host_gen = 0;
  logic [31:0] img [$];
  logic        hold8 = 1'b0;

  // Host UART model state
  int          rd_grants = 0, bytes_sent = 0, ack_n = 0, ack_cyc = -1, uart_viol = 0;
  logic [31:0] ack_last = '0;

  // IRAM model state
  logic [31:0] mw_addr [0:63];
  logic [31:0] mw_data [0:63];
  int          mw_n = 0, mem_req_cycles = 0, mem_viol = 0;

  int nrst_rise = -1;

  initial begin : host
    int idx, gen_seen, delay, dg_delay;
    logic gprev, gwr;
    logic [31:0] wval, tmp;
    idx = 0; gen_seen = 0; delay = 0; dg_delay = -1; gprev = 0; gwr = 0; wval = '0;
    uart_gnt = 1'b0; uart_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dg_model = 1'b0;
      uart_gnt = 1'b0;
      if (!anrst) begin
        dg_delay = -1; gprev = 0; delay = 0;
        continue;
      end
      if (gen_seen != host_gen) begin gen_seen = host_gen; idx = 0; end
      if (gprev) begin
        gprev = 0;
        if (gwr) begin ack_n++; ack_last = wval; ack_cyc = cyc; end
        else begin rd_grants++; dg_delay = int'($urandom_range(0, 2)); end
      end else if (uart_req) begin
        if (uart_addr !== 32'hffff_ffff) uart_viol++;
        if (!((uart_wstrb === 4'h0 && uart_wdata_oe === 1'b0) ||
              (uart_wstrb === 4'hf && uart_wdata_oe === 1'b1))) uart_viol++;
        if (delay > 0) delay--;
        else begin
          uart_gnt = 1'b1; gprev = 1; gwr = (uart_wstrb == 4'hf); wval = uart_wdata;
          delay = int'($urandom_range(0, 3));
        end
      end
      if (dg_delay == 0) begin
        tmp = $urandom();
        uart_rdata = {tmp[31:8], (idx < 64) ? host_bytes[idx] : 8'h00};
        dg_model = 1'b1;
        idx++; bytes_sent++; dg_delay = -1;
      end else if (dg_delay > 0) dg_delay--;
    end
  end

  initial begin : iram
    int delay, held;
    logic gprev;
    delay = 0; held = 0; gprev = 0;
    mem_gnt = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (!anrst) begin gprev = 0; continue; end
      if (!hold8) held = 0;
      if (mem_req) mem_req_cycles++;
      if (gprev) gprev = 0;
      else if (mem_req) begin
        if (mem_wstrb !== 4'hf || mem_wdata_oe !== 1'b1) mem_viol++;
        if (hold8 && mem_addr == 32'h8 && held < 20) held++;
        else if (delay > 0) delay--;
        else begin
          mem_gnt = 1'b1; gprev = 1;
          if (mw_n < 64) begin mw_addr[mw_n] = mem_addr; mw_data[mw_n] = mem_wdata; end
          mw_n++;
          delay = int'($urandom_range(0, 3));
        end
      end
    end
  end

  initial begin : nrst_mon
    logic prev;
    prev = 0;
    forever begin
      @(posedge clk); #1;
      if (core_nrst && !prev) nrst_rise = cyc;
      prev = core_nrst;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_image(input logic [31:0] n, input int nwords);
    logic [31:0] w;
    img.delete();
    for (int i = 0; i < 4; i++) host_bytes[i] = n[8*i +: 8];
    for (int k = 0; k < nwords; k++) begin
      w = (k == 0) ? 32'hfff0_0093 : $urandom();
      img.push_back(w);
      for (int i = 0; i < 4; i++) host_bytes[4 + 4*k + i] = w[8*i +: 8];
    end
    host_gen++;
  endtask

  int mw0, rd0, ack0, mrc0, b0;
  task automatic snap();
    mw0 = mw_n; rd0 = rd_grants; ack0 = ack_n; mrc0 = mem_req_cycles; b0 = bytes_sent;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(core_nrst || error) && n < 3000) begin tick(); n++; end
    chk({tag, "_done"}, {31'b0, core_nrst | error}, 32'd1);
  endtask

  // Reference: N > MAXW is refused with NAK and nothing written; otherwise N words land at 4*i.
  task automatic run_check(input string tag, input logic [31:0] n);
    bit nak;
    int nw;
    nak = (n > MAXW);
    nw  = nak ? 0 : int'(n);
    wait_done(tag);
    chk({tag, "_acks"}, ack_n - ack0, 1);
    chk({tag, "_resp"}, ack_last, nak ? 32'h15 : 32'h06);
    chk({tag, "_nrst"}, {31'b0, core_nrst}, {31'b0, !nak});
    chk({tag, "_err"}, {31'b0, error}, {31'b0, nak});
    chk({tag, "_cnt"}, {28'b0, word_cnt}, nw);
    chk({tag, "_nwr"}, mw_n - mw0, nw);
    chk({tag, "_reads"}, rd_grants - rd0, 4 + 4*nw);
    for (int i = 0; i < nw; i++) begin
      chk({tag, "_addr"}, mw_addr[mw0 + i], 32'(4*i));
      chk({tag, "_data"}, mw_data[mw0 + i], img[i]);
    end
    if (!nak) chk({tag, "_rise"}, nrst_rise, ack_cyc);
    if (nw == 0) chk({tag, "_nomem"}, mem_req_cycles - mrc0, 0);
  endtask

  initial begin : main
    int n, bad, uart_busy;
    anrst = 1'b0;
    tick(); tick();
    chk("rst_uart_req", {31'b0, uart_req}, 0);
    chk("rst_uart_addr", uart_addr, 0);
    chk("rst_uart_wstrb", {28'b0, uart_wstrb}, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_nrst", {31'b0, core_nrst}, 0);
    chk("rst_err", {31'b0, error}, 0);
    chk("rst_cnt", {28'b0, word_cnt}, 0);

    // N=5 image from reset
    load_image(32'd5, 5);
    snap();
    anrst = 1'b1;
    run_check("a_n5", 32'd5);

    // N=0
    load_image(32'd0, 0);
    snap(); pulse_reload();
    run_check("b_n0", 32'd0);

    // N=9 refused, then recovery with N=1
    load_image(32'd9, 0);
    snap(); pulse_reload();
    run_check("c_n9", 32'd9);
    load_image(32'd1, 1);
    snap(); pulse_reload();
    chk("c_err_clr", {31'b0, error}, 0);
    run_check("c_n1", 32'd1);

    // Full-width length and exact-maximum boundaries
    load_image(32'hffff_ffff, 0);
    snap(); pulse_reload();
    run_check("g_nmax", 32'hffff_ffff);
    load_image(32'd8, 8);
    snap(); pulse_reload();
    run_check("h_n8", 32'd8);

    // IRAM grant withheld on word 2, with stray data_gnt pulses
    load_image(32'd4, 4);
    hold8 = 1'b1;
    snap(); pulse_reload();
    n = 0;
    while (!(mem_req && mem_addr == 32'h8) && n < 2000) begin tick(); n++; end
    chk("d_hold_seen", {31'b0, mem_req && mem_addr == 32'h8}, 1);
    chk("d_hold_cnt", {28'b0, word_cnt}, 2);
    chk("d_hold_data", mem_wdata, img[2]);
    bad = 0; uart_busy = 0;
    for (int i = 0; i < 18; i++) begin
      dg_force = (i == 3 || i == 9);
      tick();
      dg_force = 1'b0;
      if (!(mem_req === 1'b1 && mem_addr === 32'h8 && mem_wdata === img[2])) bad++;
      if (uart_req) uart_busy++;
    end
    chk("d_hold_stable", bad, 0);
    chk("d_hold_no_uart", uart_busy, 0);
    run_check("d_hold", 32'd4);
    hold8 = 1'b0;

    // Async reset after two bytes of word 3
    load_image(32'd4, 4);
    snap(); pulse_reload();
    n = 0;
    while ((bytes_sent - b0) < 18 && n < 3000) begin tick(); n++; end
    tick();
    chk("e_pre_cnt", {28'b0, word_cnt}, 3);
    anrst = 1'b0;
    #1;
    chk("e_rst_uart_req", {31'b0, uart_req}, 0);
    chk("e_rst_uart_addr", uart_addr, 0);
    chk("e_rst_mem_req", {31'b0, mem_req}, 0);
    chk("e_rst_nrst", {31'b0, core_nrst}, 0);
    chk("e_rst_err", {31'b0, error}, 0);
    chk("e_rst_cnt", {28'b0, word_cnt}, 0);
    tick(); tick();
    load_image(32'd2, 2);
    snap();
    anrst = 1'b1;
    run_check("e_n2", 32'd2);

    // Reload in S_DONE coinciding with a stray data_gnt
    load_image(32'd1, 1);
    snap();
    reload = 1'b1; dg_force = 1'b1;
    tick();
    reload = 1'b0; dg_force = 1'b0;
    chk("f_nrst", {31'b0, core_nrst}, 0);
    chk("f_cnt", {28'b0, word_cnt}, 0);
    chk("f_err", {31'b0, error}, 0);
    run_check("f_n1", 32'd1);

    chk("uart_protocol", uart_viol, 0);
    chk("mem_protocol", mem_viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ladybird_boot_loader.md
Name: ladybird_boot_loader

Overview:
- Boot sequencer between the host UART serial interface and the instruction RAM write port.
- Reads a length-prefixed program image byte-by-byte from the serial interface bus and assembles 32-bit words.
- Writes each word into IRAM through the IRAM bus arbitrator, acknowledges the host over UART, then releases the core reset.
- Replaces bench-side instruction preloading so that both hardware and simulation boot from UART.

Parameters:
- XLEN, 32, word width; must equal ladybird_config::XLEN.
- BASE_ADDR, 32'h0, byte address of the first IRAM word.
- MAX_WORDS, 8, largest accepted image size in words.
- UART_ADDR, 32'hffff_ffff, address driven on uart_bus for all UART accesses.

Ports:
- clk  in  1  clock.
- anrst  in  1  asynchronous active-low reset.
- uart_bus  ladybird_bus master  XLEN  to the serial interface; read = wstrb '0, write = wstrb '1.
- mem_bus  ladybird_bus master  XLEN  to the IRAM arbitrator input; writes only.
- reload  in  1  single-cycle pulse; restarts boot, honoured only in S_DONE or S_ERR.
- core_nrst  out  1  active-low core reset; high only in S_DONE.
- error  out  1  high in S_ERR.
- word_cnt  out  $clog2(MAX_WORDS+1)  number of words written so far.

Behaviour:
- Reset: all req 0, wstrb 0, addr 0, data 'z, core_nrst 0, error 0, word_cnt 0, state S_LEN, byte index 0.
- Request handshake, both buses:
  - Raise req with stable addr, wstrb and data.
  - Hold until gnt is sampled high at a posedge.
  - Drop req in the cycle after the grant; a new req may not be raised in that same cycle.
  - At most one outstanding request per bus.
- Data bus drive: drive data only while a write req is high; otherwise 'z.
- UART byte read:
  - Issue a read req (wstrb '0).
  - After gnt, wait for uart_bus.data_gnt; capture data[7:0] on that edge. Arrival is at least 1 cycle after gnt, with no upper bound.
  - Shift the byte into the word register little-endian: byte i goes to bits [8i+7:8i].
- States:
  - S_LEN: read 4 bytes into the length register N.
    - N > MAX_WORDS → S_NAK.
    - N == 0 → S_ACK.
    - Otherwise → S_DATA.
  - S_DATA: read 4 bytes into the word register → S_MEM.
  - S_MEM: write mem_bus with addr = BASE_ADDR + (word_cnt << 2), wstrb '1, data = word.
    - On gnt: word_cnt += 1.
    - If the new count == N → S_ACK, else → S_DATA.
  - S_ACK: write uart_bus with data = 32'h06 → S_DONE on gnt.
  - S_NAK: write uart_bus with data = 32'h15 → S_ERR on gnt.
  - S_DONE: core_nrst = 1, registered, starting the cycle after the ACK gnt.
  - S_ERR: error = 1, core_nrst = 0.
  - From S_DONE or S_ERR, reload → S_LEN: core_nrst 0 and error 0 next cycle, word_cnt 0, byte index 0, N cleared.
- Simultaneous events / boundaries:
  - reload in any other state is ignored.
  - data_gnt is ignored unless a read is outstanding.
  - Counts are compared at full 32-bit width: N = 32'hffff_ffff → NAK; N == MAX_WORDS is accepted.
  - Address arithmetic wraps modulo 2^32.
- Async reset at any point, including a held req, returns to the reset values immediately. The loader does not complete a pending transaction; downstream blocks share anrst.
- Throughput: each word costs 4 UART reads plus 1 memory write; no pipelining.

Decomposition:
- Shared package ladybird_config: the boot state enum type, constants BOOT_ACK = 8'h06 and BOOT_NAK = 8'h15, and the UART address constant.
- One natural sub-module: ladybird_boot_byte_reader.
  - Performs the UART read handshake.
  - Emits byte_valid/byte_data to the FSM.
  - Drives uart_bus during read phases.
- The top FSM muxes uart_bus ownership for ACK/NAK writes.

Test Plan:
- Image N=5 (bytes 05 00 00 00, then 5 LE words such as fff00093…), UART model grants with 0-3 cycle random delay:
  - IRAM words 0-4 match the image.
  - Host receives 8'h06.
  - core_nrst rises exactly 1 cycle after the ACK gnt; word_cnt = 5.
- N=0: no mem_bus req ever; ACK 8'h06 sent; core_nrst = 1.
- N=9 with MAX_WORDS=8:
  - Host receives 8'h15; error = 1; core_nrst stays 0; no mem_bus req.
  - Then pulse reload and send a valid N=1 image → error 0, ACK, core_nrst 1.
- mem_bus gnt withheld for 20 cycles during word 2:
  - req, addr 32'h8 and data stay stable.
  - No further UART read is issued until the gnt.
  - data_gnt pulses with no read outstanding are ignored.
- anrst asserted mid S_DATA, after 2 bytes of word 3:
  - All outputs return to reset values.
  - Restarting with a full N=2 image loads correctly from address 0.
- In S_DONE, a reload pulse coinciding with a spurious data_gnt:
  - Loader returns to S_LEN; core_nrst 0 the next cycle; word_cnt 0.
